// File: rtl/tron_bram_sched.sv
// Trail-BRAM sequencer for the TRON arena. Each tick it reads both head cells,
// resolves collisions and writes the surviving heads. It also zeroes the map after reset or restart.
module tron_bram_sched #(
    parameter int GRID_W = 160,
    parameter int GRID_H = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              clear_req,
    input  logic [7:0]        p1_x,
    input  logic [6:0]        p1_y,
    input  logic [7:0]        p2_x,
    input  logic [6:0]        p2_y,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata,
    output logic              busy,
    output logic              step_done,
    output logic              p1_lost,
    output logic              p2_lost
);

    typedef enum logic [2:0] {IDLE, CLEAR, RD1, RD2, CHK, WR1, WR2, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(GRID_W * GRID_H - 1);

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] x, input logic [6:0] y);
        return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
    endfunction

    function automatic logic is_wall(input logic [7:0] x, input logic [6:0] y);
        return (32'(x) >= GRID_W) || (32'(y) >= GRID_H);
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                clear_pend_q, clear_pend_d;
    logic                p1_lost_q, p1_lost_d, p2_lost_q, p2_lost_d;
    logic [ADDR_W-1:0]   a1_q, a1_d, a2_q, a2_d;
    logic                w1_q, w1_d, w2_q, w2_d;
    logic                same_q, same_d;
    logic [1:0]          d1_q, d1_d;
    logic                n1_q, n1_d, n2_q, n2_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [1:0]          mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
    logic                step_done_q, step_done_d;
    logic                w1_in, w2_in;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clear_pend_d = clear_pend_q | clear_req;
        p1_lost_d    = p1_lost_q;
        p2_lost_d    = p2_lost_q;
        a1_d         = a1_q;
        a2_d         = a2_q;
        w1_d         = w1_q;
        w2_d         = w2_q;
        same_d       = same_q;
        d1_d         = d1_q;
        n1_d         = n1_q;
        n2_d         = n2_q;
        w1_in        = is_wall(p1_x, p1_y);
        w2_in        = is_wall(p2_x, p2_y);

        case (state_q)
            IDLE: begin
                if (clear_pend_q || clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (tick && !p1_lost_q && !p2_lost_q) begin
                    w1_d    = w1_in;
                    w2_d    = w2_in;
                    a1_d    = w1_in ? '0 : cell_addr(p1_x, p1_y);
                    a2_d    = w2_in ? '0 : cell_addr(p2_x, p2_y);
                    same_d  = !w1_in && !w2_in && (p1_x == p2_x) && (p1_y == p2_y);
                    state_d = RD1;
                end
            end
            CLEAR: begin
                // The first cycle out of reset presents no write yet, so only
                // advance once the current address has actually been written.
                if (mem_we_q) begin
                    if (cnt_q == LAST) begin
                        state_d      = IDLE;
                        p1_lost_d    = 1'b0;
                        p2_lost_d    = 1'b0;
                        clear_pend_d = clear_req;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RD1: state_d = RD2;
            RD2: begin
                d1_d    = mem_rdata;
                state_d = CHK;
            end
            CHK: begin
                n1_d      = w1_q || (d1_q != 2'b00) || same_q;
                n2_d      = w2_q || (mem_rdata != 2'b00) || same_q;
                p1_lost_d = p1_lost_q | n1_d;
                p2_lost_d = p2_lost_q | n2_d;
                state_d   = WR1;
            end
            WR1:     state_d = WR2;
            WR2:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they stay 0 in reset.
        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_wdata_d = 2'b00;
        case (state_d)
            CLEAR: begin
                mem_we_d   = 1'b1;
                mem_addr_d = cnt_d;
            end
            RD1: mem_addr_d = a1_d;
            RD2: mem_addr_d = a2_d;
            WR1: begin
                mem_addr_d  = a1_d;
                mem_we_d    = !n1_d;
                mem_wdata_d = 2'b01;
            end
            WR2: begin
                mem_addr_d  = a2_d;
                mem_we_d    = !n2_d;
                mem_wdata_d = 2'b10;
            end
            default: ;
        endcase
        busy_d      = (state_d != IDLE);
        step_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            clear_pend_q <= 1'b0;
            p1_lost_q    <= 1'b0;
            p2_lost_q    <= 1'b0;
            a1_q         <= '0;
            a2_q         <= '0;
            w1_q         <= 1'b0;
            w2_q         <= 1'b0;
            same_q       <= 1'b0;
            d1_q         <= 2'b00;
            n1_q         <= 1'b0;
            n2_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 2'b00;
            busy_q       <= 1'b0;
            step_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clear_pend_q <= clear_pend_d;
            p1_lost_q    <= p1_lost_d;
            p2_lost_q    <= p2_lost_d;
            a1_q         <= a1_d;
            a2_q         <= a2_d;
            w1_q         <= w1_d;
            w2_q         <= w2_d;
            same_q       <= same_d;
            d1_q         <= d1_d;
            n1_q         <= n1_d;
            n2_q         <= n2_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            step_done_q  <= step_done_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign step_done = step_done_q;
    assign p1_lost   = p1_lost_q;
    assign p2_lost   = p2_lost_q;

endmodule

// File: doc/tron_bram_sched.md
Name: tron_bram_sched

Overview:
- Sequencer for the single-port, 2-bit-per-cell trail BRAM of the 160x120 TRON arena.
- Per game tick: reads the P1 and P2 head cells, decides collisions, then writes the surviving heads into the trail map.
- Zeroes the whole map after reset and on round restart.
- Sits between the game-logic/movement block (coordinates, tick) and the trail BRAM; the VGA path uses the BRAM's other port and is not arbitrated here.

Parameters:
- GRID_W, 160, arena width in cells.
- GRID_H, 120, arena height in cells.
- ADDR_W, 15, BRAM address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- tick  in  1  one-cycle game step pulse
- clear_req  in  1  one-cycle round-restart request
- p1_x  in  8  P1 head column
- p1_y  in  7  P1 head row
- p2_x  in  8  P2 head column
- p2_y  in  7  P2 head row
- mem_addr  out  ADDR_W  BRAM address
- mem_we  out  1  BRAM write enable
- mem_wdata  out  2  write data: bit0 = P1 trail, bit1 = P2 trail
- mem_rdata  in  2  BRAM read data; synchronous read, valid the cycle after mem_addr is presented
- busy  out  1  high whenever state is not IDLE
- step_done  out  1  one-cycle pulse when a tick sequence completes
- p1_lost  out  1  sticky P1 loss flag
- p2_lost  out  1  sticky P2 loss flag

Behaviour:
- Reset (async, resetn low):
  - All outputs 0, state CLEAR, clear counter 0, clear_pend 0.
  - The map is zeroed after every reset with no request needed.
  - Reset mid-sequence abandons it; no partial write completes after resetn deasserts.
- Address mapping: addr = y*GRID_W + x, computed at ADDR_W bits.
- Out of range: x >= GRID_W or y >= GRID_H is a wall hit.
  - That player is lost with no memory read.
  - mem_addr for that slot is driven 0 and the read data is ignored.
- States: IDLE, CLEAR, RD1, RD2, CHK, WR1, WR2, DONE.
- CLEAR:
  - mem_we=1, mem_wdata=0, mem_addr=counter; counter increments 0..GRID_W*GRID_H-1 (19200 cycles).
  - After the last address: p1_lost=p2_lost=0, clear_pend=0, go to IDLE.
  - Ticks arriving during CLEAR are dropped.
- clear_req:
  - Sets clear_pend in any state.
  - In IDLE, clear_pend (or clear_req that cycle) has priority over tick and enters CLEAR.
  - During a tick sequence the sequence finishes (through DONE), then CLEAR is entered from IDLE.
- IDLE + tick:
  - Accepted only if clear_pend=0 and p1_lost=0 and p2_lost=0; otherwise dropped with no step_done.
  - On acceptance, latch all four coordinates and go to RD1.
- RD1: mem_addr = P1 address, mem_we=0.
- RD2: mem_addr = P2 address; capture mem_rdata as d1.
- CHK: capture mem_rdata as d2, then evaluate:
  - n1 = P1 wall hit or d1 != 0
  - n2 = P2 wall hit or d2 != 0
  - head-on (both in range and equal coordinates): n1 = n2 = 1
  - p1_lost |= n1; p2_lost |= n2 (registered at end of CHK)
- WR1: if !n1, mem_we=1, mem_addr=P1 address, mem_wdata=2'b01; else mem_we=0.
- WR2: if !n2, mem_we=1, mem_addr=P2 address, mem_wdata=2'b10; else mem_we=0.
- DONE: step_done=1 for one cycle, then IDLE.
- Latency: tick accepted in cycle T gives step_done high in cycle T+6. Minimum tick spacing for back-to-back steps is 7 cycles; ticks arriving while busy are dropped.
- mem_we is 0 in IDLE, RD1, RD2, CHK and DONE.
- Loss flags change only in CHK (set) and at CLEAR completion (clear).

Test Plan:
- Reset release -> busy=1 for 19200 cycles, writes 0 to addr 0..19199 each once, then busy=0, p1_lost=p2_lost=0.
- Empty map, tick with P1(10,5), P2(20,5) -> reads addr 810 then 820, writes 2'b01 @810 and 2'b10 @820, step_done exactly 6 cycles after tick, no loss.
- Second tick, P1 moves to (20,5) (P2 trail), P2 at (21,5) -> p1_lost=1, p2_lost=0, only addr 821 written with 2'b10; next tick -> dropped, no step_done.
- Head-on: after clear, both at (50,60) -> p1_lost=p2_lost=1, no writes.
- Wall: P1 x=160 -> p1_lost=1 with no P1 read address; P2 y=120 -> p2_lost=1.
- clear_req during RD2 -> sequence completes with step_done, then CLEAR runs and flags clear; resetn pulsed during WR1 -> no write at that address, CLEAR restarts at addr 0.
